// File: rtl/carbon_cai_comp_writer.sv
// carbon_cai_comp_writer: writes 16-byte completion records (four 32-bit beats)
// into a host ring, then pulses a doorbell and bumps the producer index.
// Optional build macro CARBON_CAI_COMP_FULL_CHECK_EN: when defined, new
// completions are held off while the ring is full relative to comp_cons_idx;
// when undefined, comp_cons_idx is ignored and old records are overwritten.
module carbon_cai_comp_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [63:0] comp_base,
  input  logic [31:0] comp_ring_mask,
  input  logic [31:0] comp_cons_idx,
  input  logic        comp_valid,
  output logic        comp_ready,
  input  logic [31:0] comp_tag,
  input  logic [15:0] comp_status,
  input  logic [15:0] comp_ext_status,
  input  logic [31:0] comp_bytes_written,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  output logic        comp_doorbell,
  output logic [31:0] comp_prod_idx,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_RING  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [31:0] prod_idx_q, prod_idx_d;
  logic        doorbell_q, doorbell_d;

  // Record snapshot taken at acceptance; held for the whole record.
  logic [31:0] tag_q;
  logic [15:0] status_q;
  logic [15:0] ext_q;
  logic [31:0] bytes_q;
  logic [63:0] base_q;
  logic [31:0] mask_q;
  logic [31:0] slot_idx_q;

  logic        full_s;
  logic        accept_s;
  logic [63:0] rec_addr_s;

`ifdef CARBON_CAI_COMP_FULL_CHECK_EN
  // Ring is full when the producer is a whole ring ahead of the consumer.
  assign full_s = ((prod_idx_q - comp_cons_idx) == (comp_ring_mask + 32'd1));
`else
  logic unused_cons_s;
  assign unused_cons_s = ^comp_cons_idx;
  assign full_s = 1'b0;
`endif

  // Ready is suppressed while rst is high, since state only reads IDLE then.
  assign comp_ready    = ~rst & (state_q == ST_IDLE) & enable & ~full_s;
  assign accept_s      = comp_valid & comp_ready;
  assign mem_req       = (state_q == ST_WRITE);
  assign busy          = (state_q != ST_IDLE);
  assign mem_wstrb     = 4'hF;
  assign comp_doorbell = doorbell_q;
  assign comp_prod_idx = prod_idx_q;

  // Slot byte offset is (idx & mask) * 16, widened to 64 bits before the add.
  assign rec_addr_s = base_q + {28'd0, (slot_idx_q & mask_q), 4'd0};
  assign mem_addr   = rec_addr_s + {60'd0, beat_q, 2'd0};

  // Beat data selection from the latched record fields.
  always_comb begin
    mem_wdata = 32'h0;
    case (beat_q)
      2'd0:    mem_wdata = tag_q;
      2'd1:    mem_wdata = {ext_q, status_q};
      2'd2:    mem_wdata = bytes_q;
      2'd3:    mem_wdata = 32'h0;
      default: mem_wdata = 32'h0;
    endcase
  end

  // Next-state logic: accept, stream four beats, ring the doorbell.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    prod_idx_d = prod_idx_q;
    doorbell_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_WRITE;
          beat_d  = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          if (beat_q == 2'd3) begin
            // Doorbell and index update become visible together in RING.
            state_d    = ST_RING;
            doorbell_d = 1'b1;
            prod_idx_d = prod_idx_q + 32'd1;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_RING: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state registers; reset abandons any partial record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_q     <= 2'd0;
      prod_idx_q <= 32'd0;
      doorbell_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      prod_idx_q <= prod_idx_d;
      doorbell_q <= doorbell_d;
    end
  end

  // Snapshot of the completion and ring geometry at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q      <= 32'd0;
      status_q   <= 16'd0;
      ext_q      <= 16'd0;
      bytes_q    <= 32'd0;
      base_q     <= 64'd0;
      mask_q     <= 32'd0;
      slot_idx_q <= 32'd0;
    end else if (accept_s) begin
      tag_q      <= comp_tag;
      status_q   <= comp_status;
      ext_q      <= comp_ext_status;
      bytes_q    <= comp_bytes_written;
      base_q     <= comp_base;
      mask_q     <= comp_ring_mask;
      slot_idx_q <= prod_idx_q;
    end
  end

endmodule

// File: tb/tb_carbon_cai_comp_writer.sv
// Directed bench for carbon_cai_comp_writer.
module tb_carbon_cai_comp_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [63:0] comp_base;
  logic [31:0] comp_ring_mask;
  logic [31:0] comp_cons_idx;
  logic        comp_valid;
  logic        comp_ready;
  logic [31:0] comp_tag;
  logic [15:0] comp_status;
  logic [15:0] comp_ext_status;
  logic [31:0] comp_bytes_written;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic        comp_doorbell;
  logic [31:0] comp_prod_idx;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [63:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  int          db_q[$];
  int          acc_q[$];

  carbon_cai_comp_writer dut (
    .clk(clk), .rst(rst), .enable(enable), .comp_base(comp_base),
    .comp_ring_mask(comp_ring_mask), .comp_cons_idx(comp_cons_idx),
    .comp_valid(comp_valid), .comp_ready(comp_ready), .comp_tag(comp_tag),
    .comp_status(comp_status), .comp_ext_status(comp_ext_status),
    .comp_bytes_written(comp_bytes_written), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .comp_doorbell(comp_doorbell),
    .comp_prod_idx(comp_prod_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture handshakes mid-cycle; they complete at the following rising edge.
  always @(negedge clk) begin
    if (mem_req && mem_ready) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      wc_q.push_back(cyc);
      total++;
      if (mem_wstrb !== 4'hF) begin
        bad++;
        $display("FAIL wstrb: got %h want f", mem_wstrb);
      end
    end
    if (comp_doorbell) db_q.push_back(cyc);
    if (comp_valid && comp_ready) acc_q.push_back(cyc);
  end

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); db_q.delete(); acc_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_log();
  endtask

  task automatic offer(input logic [31:0] tag, input logic [15:0] st,
                       input logic [15:0] ext, input logic [31:0] by);
    bit ok;
    ok = 1'b0;
    comp_valid = 1'b1; comp_tag = tag; comp_status = st;
    comp_ext_status = ext; comp_bytes_written = by;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (comp_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    comp_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept: tag %h not accepted within budget", tag);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    total++;
    if (busy) begin
      bad++;
      $display("FAIL idle_timeout: busy still %b want 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; comp_valid = 1'b1; mem_ready = 1'b1;
    comp_base = 64'h4000; comp_ring_mask = 32'hFF; comp_cons_idx = 32'd0;
    comp_tag = 32'd0; comp_status = 16'd0; comp_ext_status = 16'd0;
    comp_bytes_written = 32'd0;
    #3;
    total++; if (comp_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", comp_ready); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", mem_req); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (comp_doorbell !== 1'b0) begin bad++; $display("FAIL rst_db: got %b want 0", comp_doorbell); end
    total++; if (comp_prod_idx !== 32'd0) begin bad++; $display("FAIL rst_prod: got %h want 0", comp_prod_idx); end
    comp_valid = 1'b0;
    do_reset();
  endtask

  task automatic test_basic();
    logic [63:0] ea[4];
    logic [31:0] ed[4];
    ea = '{64'h4000, 64'h4004, 64'h4008, 64'h400C};
    ed = '{32'h1, 32'h0, 32'h4, 32'h0};
    clear_log();
    offer(32'd1, 16'd0, 16'd0, 32'd4);
    wait_idle();
    total++; if (wa_q.size() != 4) begin bad++; $display("FAIL basic_nbeats: got %0d want 4", wa_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (wa_q[i] !== ea[i]) begin bad++; $display("FAIL basic_addr%0d: got %h want %h", i, wa_q[i], ea[i]); end
      total++; if (wd_q[i] !== ed[i]) begin bad++; $display("FAIL basic_data%0d: got %h want %h", i, wd_q[i], ed[i]); end
    end
    total++; if (wc_q[3] - wc_q[0] != 3) begin bad++; $display("FAIL basic_gapless: got %0d want 3", wc_q[3] - wc_q[0]); end
    total++; if (db_q.size() != 1) begin bad++; $display("FAIL basic_ndb: got %0d want 1", db_q.size()); end
    total++; if (db_q[0] - acc_q[0] != 5) begin bad++; $display("FAIL basic_latency: got %0d want 5", db_q[0] - acc_q[0]); end
    total++; if (comp_prod_idx !== 32'd1) begin bad++; $display("FAIL basic_prod: got %h want 1", comp_prod_idx); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    offer(32'd2, 16'h11, 16'h22, 32'd8);
    offer(32'd3, 16'h33, 16'h44, 32'd12);
    wait_idle();
    total++; if (wa_q.size() != 8) begin bad++; $display("FAIL b2b_nbeats: got %0d want 8", wa_q.size()); end
    total++; if (wa_q[0] !== 64'h4010) begin bad++; $display("FAIL b2b_addr0: got %h want 4010", wa_q[0]); end
    total++; if (wa_q[4] !== 64'h4020) begin bad++; $display("FAIL b2b_addr1: got %h want 4020", wa_q[4]); end
    total++; if (wd_q[1] !== 32'h0022_0011) begin bad++; $display("FAIL b2b_stat: got %h want 00220011", wd_q[1]); end
    total++; if (wd_q[4] !== 32'd3) begin bad++; $display("FAIL b2b_tag: got %h want 3", wd_q[4]); end
    total++; if (wd_q[6] !== 32'd12) begin bad++; $display("FAIL b2b_bytes: got %h want c", wd_q[6]); end
    total++; if (db_q.size() != 2) begin bad++; $display("FAIL b2b_ndb: got %0d want 2", db_q.size()); end
    total++; if (comp_prod_idx !== 32'd3) begin bad++; $display("FAIL b2b_prod: got %h want 3", comp_prod_idx); end
  endtask

  task automatic test_wrap();
    do_reset();
    comp_ring_mask = 32'd1;
    offer(32'hA0, 16'd0, 16'd0, 32'd0);
    // Geometry changes mid-record must not disturb the record in flight.
    comp_base = 64'h9000; comp_ring_mask = 32'hFF;
    wait_idle();
    comp_base = 64'h4000; comp_ring_mask = 32'd1;
    offer(32'hA1, 16'd0, 16'd0, 32'd0);
    wait_idle();
    offer(32'hA2, 16'd0, 16'd0, 32'd0);
    wait_idle();
    total++; if (wa_q[0] !== 64'h4000) begin bad++; $display("FAIL wrap_a0: got %h want 4000", wa_q[0]); end
    total++; if (wa_q[3] !== 64'h400C) begin bad++; $display("FAIL wrap_a0b3: got %h want 400c", wa_q[3]); end
    total++; if (wa_q[4] !== 64'h4010) begin bad++; $display("FAIL wrap_a1: got %h want 4010", wa_q[4]); end
    total++; if (wa_q[8] !== 64'h4000) begin bad++; $display("FAIL wrap_a2: got %h want 4000", wa_q[8]); end
    total++; if (wd_q[8] !== 32'hA2) begin bad++; $display("FAIL wrap_d2: got %h want a2", wd_q[8]); end
    total++; if (comp_prod_idx !== 32'd3) begin bad++; $display("FAIL wrap_prod: got %h want 3", comp_prod_idx); end
  endtask

  task automatic test_backpressure();
    do_reset();
    comp_ring_mask = 32'hFF;
    offer(32'hB0, 16'h1234, 16'h5678, 32'd64);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (mem_req !== 1'b1 || mem_addr !== 64'h4004) begin bad++; $display("FAIL bp_addr%0d: got req=%b addr=%h want 1/4004", i, mem_req, mem_addr); end
      total++; if (mem_wdata !== 32'h5678_1234) begin bad++; $display("FAIL bp_data%0d: got %h want 56781234", i, mem_wdata); end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    wait_idle();
    total++; if (db_q.size() != 1) begin bad++; $display("FAIL bp_ndb: got %0d want 1", db_q.size()); end
    total++; if (db_q[0] - acc_q[0] != 10) begin bad++; $display("FAIL bp_latency: got %0d want 10", db_q[0] - acc_q[0]); end
    total++; if (wd_q[2] !== 32'd64) begin bad++; $display("FAIL bp_bytes: got %h want 40", wd_q[2]); end
  endtask

  task automatic test_full();
    do_reset();
    comp_ring_mask = 32'd1; comp_cons_idx = 32'd0;
    offer(32'hC0, 16'd0, 16'd0, 32'd0);
    wait_idle();
    offer(32'hC1, 16'd0, 16'd0, 32'd0);
    wait_idle();
`ifdef CARBON_CAI_COMP_FULL_CHECK_EN
    total++; if (comp_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", comp_ready); end
    comp_cons_idx = 32'd1;
    @(posedge clk); #1;
    total++; if (comp_ready !== 1'b1) begin bad++; $display("FAIL full_release: got %b want 1", comp_ready); end
`else
    total++; if (comp_ready !== 1'b1) begin bad++; $display("FAIL nofull_ready: got %b want 1", comp_ready); end
    offer(32'hC2, 16'd0, 16'd0, 32'd0);
    wait_idle();
    total++; if (comp_prod_idx !== 32'd3) begin bad++; $display("FAIL nofull_prod: got %h want 3", comp_prod_idx); end
    total++; if (wa_q[8] !== 64'h4000) begin bad++; $display("FAIL nofull_addr: got %h want 4000", wa_q[8]); end
`endif
    comp_cons_idx = 32'd0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    comp_ring_mask = 32'hFF;
    offer(32'hD0, 16'd0, 16'd0, 32'd0);
    wait_idle();
    clear_log();
    offer(32'hD1, 16'd0, 16'd0, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (mem_addr !== 64'h4018) begin bad++; $display("FAIL rm_beat2: got %h want 4018", mem_addr); end
    rst = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rm_force: got req=%b busy=%b want 0/0", mem_req, busy); end
    total++; if (comp_prod_idx !== 32'd0) begin bad++; $display("FAIL rm_prod: got %h want 0", comp_prod_idx); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
    end
    total++; if (db_q.size() != 0) begin bad++; $display("FAIL rm_nodb: got %0d want 0", db_q.size()); end
    clear_log();
    offer(32'hD2, 16'd0, 16'd0, 32'd0);
    wait_idle();
    total++; if (wa_q[0] !== 64'h4000 || wd_q[0] !== 32'hD2) begin bad++; $display("FAIL rm_next: got %h=%h want 4000=d2", wa_q[0], wd_q[0]); end
    total++; if (comp_prod_idx !== 32'd1) begin bad++; $display("FAIL rm_prod_after: got %h want 1", comp_prod_idx); end
  endtask

  task automatic test_enable_mid();
    clear_log();
    offer(32'hE0, 16'd0, 16'd0, 32'd0);
    enable = 1'b0;
    wait_idle();
    total++; if (db_q.size() != 1) begin bad++; $display("FAIL en_db: got %0d want 1", db_q.size()); end
    total++; if (comp_ready !== 1'b0) begin bad++; $display("FAIL en_ready: got %b want 0", comp_ready); end
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_wrap();
    test_backpressure();
    test_full();
    test_reset_mid();
    test_enable_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
